// File: rtl/eco_slice_pipe.sv
// Lane-parallel ECO test cone behind a two-stage valid/ready pipeline.
// A wrapping counter tracks completed output handshakes.
module eco_slice_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*LANES-1:0]   a,
  input  logic [4*LANES-1:0]   b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*LANES-1:0]   y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     cnt
);

  logic adv1;
  logic adv2;
  logic v1;
  logic v2;

  logic [LANES-1:0] p1_d, p3_d, p7_d;
  logic [LANES-1:0] p1_q, p3_q, p7_q;
  logic [LANES-1:0] a1_q, a3_q, b1_q, b2_q;

  logic [4*LANES-1:0] y_d;
  logic [4*LANES-1:0] y_q;
  logic [CNT_W-1:0]   cnt_q;

  // A stage may advance whenever the stage after it can take its content.
  assign adv2     = ~v2 | out_ready;
  assign adv1     = ~v1 | adv2;
  assign in_ready = adv1 & ~rst;

  // First half of the cone: only the partial products that feed stage 2.
  always_comb begin
    p1_d = '0;
    p3_d = '0;
    p7_d = '0;
    for (int k = 0; k < LANES; k++) begin
      p1_d[k] = (a[4*k] ^ b[4*k+1]) | (a[4*k] & b[4*k]);
      p3_d[k] = a[4*k+1] | (a[4*k+2] & b[4*k]);
      p7_d[k] = (a[4*k+3] | b[4*k+2]) & b[4*k+3];
    end
  end

  // Second half of the cone, fed purely from stage-1 registers.
  always_comb begin
    y_d = '0;
    for (int k = 0; k < LANES; k++) begin
      y_d[4*k]   = p1_q[k] & p3_q[k];
      y_d[4*k+1] = ~(p3_q[k] & b1_q[k]) ^ b2_q[k];
      y_d[4*k+2] = a1_q[k] | (a3_q[k] & ~p7_q[k]);
      y_d[4*k+3] = ~p7_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      p1_q <= '0;
      p3_q <= '0;
      p7_q <= '0;
      a1_q <= '0;
      a3_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      p1_q <= p1_d;
      p3_q <= p3_d;
      p7_q <= p7_d;
      for (int k = 0; k < LANES; k++) begin
        a1_q[k] <= a[4*k+1];
        a3_q[k] <= a[4*k+3];
        b1_q[k] <= b[4*k+1];
        b2_q[k] <= b[4*k+2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      y_q <= '0;
    end else if (adv2) begin
      v2  <= v1;
      y_q <= y_d;
    end
  end

  // Counts output handshakes only; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (v2 & out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign y         = y_q;
  assign out_valid = v2;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_eco_slice_pipe.sv
// Directed and randomized checks of eco_slice_pipe against a lane-function
// model with an in-order scoreboard.
module tb_eco_slice_pipe;

  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam int W     = 4 * LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     y;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt;

  int checkCount = 0;
  int failCount  = 0;

  logic [W-1:0]     sbQ[$];
  logic [CNT_W-1:0] expCnt = '0;
  logic             monOn = 1'b0;
  logic             holdActive = 1'b0;
  logic [W-1:0]     heldY = '0;

  eco_slice_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Reference for one input vector, straight from the lane equations.
  function automatic logic [W-1:0] modelY(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] r;
    logic [3:0] la, lb;
    logic p1, p3, p7;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      la = av[4*k +: 4];
      lb = bv[4*k +: 4];
      p1 = (la[0] ^ lb[1]) | (la[0] & lb[0]);
      p3 = la[1] | (la[2] & lb[0]);
      p7 = (la[3] | lb[2]) & lb[3];
      r[4*k +: 4] = {~p7, la[1] | (la[3] & ~p7), ~(p3 & lb[1]) ^ lb[2], p1 & p3};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic iv, input logic ordy);
    a         = av;
    b         = bv;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard, counter model and output-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (monOn) begin
      if (rst) begin
        sbQ.delete();
        expCnt     = '0;
        holdActive = 1'b0;
      end else begin
        checkOutput("cnt_track", 32'(cnt), 32'(expCnt));
        if (holdActive) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_y", 32'(y), 32'(heldY));
        end
        holdActive = out_valid & ~out_ready;
        heldY      = y;
        if (in_valid && in_ready)
          sbQ.push_back(modelY(a, b));
        if (out_valid && out_ready) begin
          if (sbQ.size() == 0)
            checkOutput("sb_extra", 32'd1, 32'd0);
          else
            checkOutput("y_order", 32'(y), 32'(sbQ.pop_front()));
          expCnt = expCnt + 1'b1;
        end
      end
    end
  end

  initial begin
    logic [3:0] rdyPattern;
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_y", 32'(y), 32'd0);
      checkOutput("rst_cnt", 32'(cnt), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst   = 1'b0;
    monOn = 1'b1;

    // Single hand-computed item: lanes (0,0),(F,F),(8,0),(3,1) give FE7A.
    applyStimulus(16'h38F0, 16'h10F0, 1'b1, 1'b1);
    #1;
    checkOutput("ready_after_rst", 32'(in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    checkOutput("lat_out_valid", 32'(out_valid), 32'd1);
    checkOutput("directed_y", 32'(y), 32'h0000FE7A);
    checkOutput("directed_cnt0", 32'(cnt), 32'd0);
    tick();
    checkOutput("directed_drained", 32'(out_valid), 32'd0);
    checkOutput("directed_cnt1", 32'(cnt), 32'd1);

    // Reach cnt=5, then park two items behind backpressure and reset.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b1);
      tick();
    end
    applyStimulus('0, '0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("pre_rst_cnt", 32'(cnt), 32'd5);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b0);
      tick();
    end
    applyStimulus('0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("inflight_full", 32'(in_ready), 32'd0);
    checkOutput("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_cnt", 32'(cnt), 32'd0);
    checkOutput("midrst_y", 32'(y), 32'd0);
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_stale", 32'(out_valid), 32'd0);
    end

    // Back-to-back stream of 256 items; counter comes back around to 0.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b1);
      #1;
      checkOutput("stream_ready", 32'(in_ready), 32'd1);
      if (i >= 2)
        checkOutput("stream_valid", 32'(out_valid), 32'd1);
      tick();
    end
    applyStimulus('0, '0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("stream_wrap_cnt", 32'(cnt), 32'd0);
    checkOutput("stream_sb_empty", 32'(sbQ.size()), 32'd0);

    // Backpressure: exactly two of four offers are taken.
    rdyPattern = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b0);
      #1;
      checkOutput("bp_ready", 32'(in_ready), 32'(rdyPattern[i]));
      tick();
    end
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_held_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_sb_two", 32'(sbQ.size()), 32'd2);
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      tick();
    checkOutput("bp_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("bp_cnt", 32'(cnt), 32'd2);

    // Random valid/ready traffic checked by the scoreboard.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
      tick();
    end
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      tick();
    checkOutput("rand_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("rand_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
